// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and occupancy reporting.
module pipe_stage_buf #(
  parameter int DW       = 74,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy,
  output logic [1:0]    dbg_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; a producer holds valid/data stable until that edge, and ready never
  // waits on valid of the same interface.

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic          m_valid, s_valid;
  logic [DW-1:0] m_data, s_data;
  logic [1:0]    occ_q;

  logic          m_valid_n, s_valid_n;
  logic [DW-1:0] m_data_n, s_data_n;
  logic [1:0]    state;
  logic          accept, take;

  assign state     = {s_valid, m_valid};
  assign dbg_state = state;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occupancy = occ_q;

  always_comb begin
    if (SKID != 0) in_ready = !s_valid;
    else           in_ready = !m_valid || out_ready;
  end

  assign accept = in_valid && in_ready;
  assign take   = m_valid && out_ready;

  always_comb begin
    m_valid_n = m_valid;
    s_valid_n = s_valid;
    m_data_n  = m_data;
    s_data_n  = s_data;
    if (flush) begin
      // A take in this cycle still completes downstream; only held entries die.
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
      if (CLR_DATA != 0) begin
        m_data_n = '0;
        s_data_n = '0;
      end
    end else if (SKID != 0) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_data_n  = in_data;
            m_valid_n = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            m_data_n = in_data;
          end else if (accept) begin
            s_data_n  = in_data;
            s_valid_n = 1'b1;
          end else if (take) begin
            m_valid_n = 1'b0;
          end
        end
        ST_FULL: begin
          if (take) begin
            m_data_n  = s_data;
            s_valid_n = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end else begin
      if (accept) begin
        m_data_n  = in_data;
        m_valid_n = 1'b1;
      end else if (take) begin
        m_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      occ_q   <= 2'd0;
    end else begin
      m_valid <= m_valid_n;
      s_valid <= s_valid_n;
      m_data  <= m_data_n;
      s_data  <= s_data_n;
      occ_q   <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid variants (clearing and holding data
// on flush) share one stimulus stream; a single-entry variant runs separately.
module tb_pipe_stage_buf;

  localparam int DWA = 74;
  localparam int DWB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic           a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [DWA-1:0] a_in_data = '0;
  logic           a1_in_ready, a1_out_valid, a2_in_ready, a2_out_valid;
  logic [DWA-1:0] a1_out_data, a2_out_data;
  logic [1:0]     a1_occ, a2_occ, a1_dbg, a2_dbg;

  logic           b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [DWB-1:0] b_in_data = '0;
  logic           b_in_ready, b_out_valid;
  logic [DWB-1:0] b_out_data;
  logic [1:0]     b_occ, b_dbg;

  logic [DWA-1:0] exp_q1[$];
  logic [DWA-1:0] exp_q2[$];
  logic [DWB-1:0] exp_q0[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(DWA), .SKID(1), .CLR_DATA(1)) dut1 (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a1_in_ready),
    .in_data(a_in_data), .out_valid(a1_out_valid), .out_ready(a_out_ready),
    .out_data(a1_out_data), .occupancy(a1_occ), .dbg_state(a1_dbg));

  pipe_stage_buf #(.DW(DWA), .SKID(1), .CLR_DATA(0)) dut2 (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a2_in_ready),
    .in_data(a_in_data), .out_valid(a2_out_valid), .out_ready(a_out_ready),
    .out_data(a2_out_data), .occupancy(a2_occ), .dbg_state(a2_dbg));

  pipe_stage_buf #(.DW(DWB), .SKID(0), .CLR_DATA(1)) dut0 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .dbg_state(b_dbg));

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitors: a beat presented with ready at the negedge transfers at the next posedge.
  always @(negedge clk) begin
    if (rst && a1_out_valid && a_out_ready) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_unexpected_output: got %0h expected none", a1_out_data);
      end else check("dut1_out_data", a1_out_data, exp_q1.pop_front());
    end
    if (rst && a2_out_valid && a_out_ready) begin
      if (exp_q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut2_unexpected_output: got %0h expected none", a2_out_data);
      end else check("dut2_out_data", a2_out_data, exp_q2.pop_front());
    end
    if (rst && b_out_valid && b_out_ready) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_unexpected_output: got %0h expected none", b_out_data);
      end else check("dut0_out_data", b_out_data, exp_q0.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Offer one beat to the skid pair; returns one cycle after it is accepted.
  task automatic drive_a(input logic [DWA-1:0] d);
    bit done = 1'b0;
    int k = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    while (!done && k < 50) begin
      @(negedge clk);
      if (a1_in_ready) begin
        exp_q1.push_back(d);
        exp_q2.push_back(d);
        done = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL a_accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic drive_b(input logic [DWB-1:0] d);
    bit done = 1'b0;
    int k = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    while (!done && k < 50) begin
      @(negedge clk);
      if (b_in_ready) begin
        exp_q0.push_back(d);
        done = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL b_accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic drain(input int n);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (n) cyc();
    check("drain_q1_empty", exp_q1.size(), 0);
    check("drain_q2_empty", exp_q2.size(), 0);
    check("drain_q0_empty", exp_q0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DWA-1:0] ones, alt_a, alt_5;
    ones  = 74'h3FF_FFFF_FFFF_FFFF_FFFF;
    alt_a = 74'h2AA_AAAA_AAAA_AAAA_AAAA;
    alt_5 = 74'h155_5555_5555_5555_5555;

    // Reset state
    #3;
    check("rst_out_valid", a1_out_valid, 0);
    check("rst_out_data", a1_out_data, 0);
    check("rst_occ", a1_occ, 0);
    check("rst_in_ready", a1_in_ready, 1);
    check("rst_b_in_ready", b_in_ready, 1);
    @(posedge clk); #1; rst = 1'b1;
    cyc();

    // Streaming 1..8 with out_ready high
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_a(DWA'(i));
      check("stream_occ", a1_occ, 1);
      check("stream_in_ready", a1_in_ready, 1);
    end
    drain(4);
    check("stream_occ_idle", a1_occ, 0);

    // Backpressure: A, B fill the stage, C waits upstream
    a_out_ready = 1'b0;
    drive_a(DWA'(4'hA));
    drive_a(DWA'(4'hB));
    check("bp_occ_full", a1_occ, 2);
    check("bp_in_ready_low", a1_in_ready, 0);
    check("bp_dbg_full", a1_dbg, 2'b11);
    a_in_valid = 1'b1; a_in_data = DWA'(4'hC);
    repeat (2) begin
      cyc();
      check("bp_hold_in_ready", a1_in_ready, 0);
      check("bp_hold_out_data", a1_out_data, DWA'(4'hA));
    end
    a_out_ready = 1'b1;
    drive_a(DWA'(4'hC));
    drain(4);

    // Flush while FULL, upstream offering 0xD
    a_out_ready = 1'b0;
    drive_a(DWA'(8'h11));
    drive_a(DWA'(8'h22));
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = DWA'(4'hD);
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    exp_q1.delete(); exp_q2.delete();
    check("flush_full_out_valid", a1_out_valid, 0);
    check("flush_full_occ", a1_occ, 0);
    check("flush_full_in_ready", a1_in_ready, 1);
    check("flush_full_data_clr", a1_out_data, 0);
    check("flush_full_data_hold", a2_out_data, DWA'(8'h11));
    check("flush_full_occ_hold", a2_occ, 0);
    drain(3);

    // Flush in ONE with an accept in the same cycle: the accept is dropped
    a_out_ready = 1'b0;
    drive_a(DWA'(8'h33));
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = DWA'(8'h44);
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    exp_q1.delete(); exp_q2.delete();
    check("flush_one_out_valid", a1_out_valid, 0);
    check("flush_one_occ", a1_occ, 0);
    check("flush_one_data_hold", a2_out_data, DWA'(8'h33));
    drain(3);

    // Width integrity through FULL -> ONE
    a_out_ready = 1'b0;
    drive_a(ones);
    drive_a(alt_a);
    check("width_full_out_data", a1_out_data, ones);
    a_out_ready = 1'b1;
    drive_a(alt_5);
    drain(4);

    // Asynchronous reset between edges while FULL
    a_out_ready = 1'b0;
    drive_a(DWA'(1));
    drive_a(DWA'(2));
    a_in_valid = 1'b0;
    #2; rst = 1'b0;
    #1;
    exp_q1.delete(); exp_q2.delete();
    check("arst_out_valid", a1_out_valid, 0);
    check("arst_out_data", a1_out_data, 0);
    check("arst_occ", a1_occ, 0);
    check("arst_out_data_d2", a2_out_data, 0);
    @(posedge clk); #1; rst = 1'b1;
    #1;
    check("arst_in_ready", a1_in_ready, 1);
    cyc();

    // Single-entry variant: combinational ready
    b_out_ready = 1'b0;
    drive_b(8'h03);
    b_in_valid = 1'b0;
    #1;
    check("s0_in_ready_low", b_in_ready, 0);
    check("s0_occ_one", b_occ, 1);
    b_out_ready = 1'b1;
    #1;
    check("s0_in_ready_comb", b_in_ready, 1);
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    drive_b(8'h07);
    b_out_ready = 1'b1;
    drive_b(8'h05);
    check("s0_out_data", b_out_data, 8'h05);
    check("s0_occ_stays", b_occ, 1);
    b_in_valid = 1'b0;
    drain(3);
    check("s0_occ_idle", b_occ, 0);

    // Single-entry flush: take completes, accept dropped
    b_out_ready = 1'b0;
    drive_b(8'h77);
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h99; b_out_ready = 1'b1;
    cyc();
    b_flush = 1'b0; b_in_valid = 1'b0;
    exp_q0.delete();
    check("s0_flush_out_valid", b_out_valid, 0);
    check("s0_flush_occ", b_occ, 0);
    check("s0_flush_data", b_out_data, 0);
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register; the next generation of the fixed-width stage latches between CPU stages (MEM/WB class).
- Replaces the single enable-gated register with a valid/ready handshake.
- Provides an optional two-entry skid buffer so that upstream ready is a registered signal.
- Provides synchronous flush (interrupt/branch squash) and occupancy reporting.
- Inserted between any two pipeline stages; payload is an opaque packed bus (e.g. {WB, Rdfm, aluout, dst}).

Parameters:
- DW, 74: payload width in bits (1..256).
- SKID, 1:
  - 1 = two-entry skid buffer; in_ready is registered.
  - 0 = single-entry register; in_ready is combinational from out_ready.
- CLR_DATA, 1:
  - 1 = data registers clear to 0 on flush.
  - 0 = data registers hold their value on flush (valids are still cleared).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  presented payload.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
Definitions:
- accept = in_valid & in_ready.
- take = out_valid & out_ready.
- Entries: M (main), which drives out_valid/out_data; S (skid, present only when SKID=1). Each entry has a valid bit and a data register.

Reset (rst=0, asynchronous):
- M/S valid = 0; M/S data = 0.
- out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
- Takes effect immediately, including mid-transfer; all held entries are lost.

Latency and data rules:
- Payload accepted at edge N appears on out_data with out_valid=1 after edge N (one-cycle latency).
- FIFO order is always preserved.
- in_data is ignored when in_valid=0.
- Data registers are written only on accept (or the S->M move).
- While out_valid=1 and out_ready=0, out_data is stable.

SKID=1 state machine (state = {S valid, M valid}), in_ready = !S valid (registered):
- EMPTY:
  - accept -> M<=in_data; go to ONE.
  - otherwise stay.
- ONE:
  - accept & take -> M<=in_data; stay in ONE.
  - accept only -> S<=in_data; go to FULL.
  - take only -> go to EMPTY.
  - neither -> hold.
- FULL (in_ready=0):
  - take -> M<=S; go to ONE.
  - otherwise hold.

SKID=0:
- Single entry M; in_ready = !M valid | out_ready (combinational).
- accept -> M<=in_data, M valid=1.
- take without accept -> M valid=0.
- accept & take in the same cycle -> replace M, valid stays 1.
- S does not exist; occupancy is at most 1.

Flush (priority below reset, above all else):
- At the next edge: all valids = 0, occupancy = 0, in_ready = 1.
- An accept occurring in the flush cycle is discarded.
- A take in the flush cycle is a completed transfer (downstream consumed it).
- Data registers: cleared to 0 if CLR_DATA=1; otherwise held.

Occupancy:
- occupancy = M valid + S valid, registered.
- Never exceeds 2 (SKID=1) or 1 (SKID=0).

Test Plan:
- Reset mid-operation: SKID=1, FULL with A=1, B=2; drive rst=0 between edges -> out_valid=0, out_data=0, occupancy=0 immediately, without waiting for clk. After release: in_ready=1.
- Streaming: in_valid=1, out_ready=1, in_data 1..8 on consecutive cycles -> out_data 1..8, each one cycle after acceptance; occupancy=1 throughout; in_ready never drops.
- Backpressure: out_ready=0, send A=0xA then B=0xB -> occupancy=2, in_ready=0, out_data=0xA held. C=0xC is offered and held by upstream. Raise out_ready -> outputs A, B, C in order, no duplicates or drops.
- Flush when FULL with in_valid=1, in_data=0xD -> next cycle out_valid=0, occupancy=0, in_ready=1. 0xD never appears. out_data=0 when CLR_DATA=1; unchanged when CLR_DATA=0.
- SKID=0: M valid with out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1, in_data=5 -> in_ready=1 in the same cycle; out_data=5 after the edge; occupancy stays 1.
- Width integrity, DW=74: pass all-ones (74'h3FF_FFFF_FFFF_FFFF_FFFF), then 74'h2AA..AA, then 74'h155..55 through the FULL->ONE path -> every bit reproduced exactly.
